// File: rtl/eva_ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge: one APB SETUP/ACCESS per accepted
// single AHB transfer, with the AHB data phase stalled until APB completes.
module eva_ahb2apb_bridge #(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic          hclk,
  input  logic          rst_n,
  input  logic          hsel,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [AW-1:0] haddr,
  input  logic [31:0]   hwdata,
  input  logic          hready_in,
  output logic          hready_out,
  output logic [1:0]    hresp,
  output logic [31:0]   hrdata,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [31:0]   pwdata,
  output logic [3:0]    pstrb,
  input  logic          pready,
  input  logic          pslverr,
  input  logic [31:0]   prdata
);

  typedef enum logic [2:0] {
    IDLE, LATCH, SETUP, ACCESS, RESP, ERR1, ERR2
  } state_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic [1:0]      size_q;
  logic [31:0]     cnt;
  logic            accept;
  logic            illegal;
  logic [3:0]      strb;

  // NONSEQ (10) and SEQ (11) are the only transfer types that start work.
  assign accept = hsel & hready_in & ((htrans == 2'b10) | (htrans == 2'b11));

  always_comb begin
    illegal = 1'b0;
    if (hsize > 3'd2)                              illegal = 1'b1;
    else if ((hsize == 3'd1) && haddr[0])          illegal = 1'b1;
    else if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) illegal = 1'b1;
  end

  always_comb begin
    strb = '0;
    case (size_q)
      2'd0:    strb = 4'b0001 << addr_q[1:0];
      2'd1:    strb = 4'b0011 << addr_q[1:0];
      default: strb = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      state      <= IDLE;
      hready_out <= 1'b1;
      hresp      <= HRESP_OKAY;
      hrdata     <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        // IDLE, RESP and ERR2 share the accept decision; otherwise settle in IDLE.
        IDLE, RESP, ERR2: begin
          if (accept) begin
            addr_q     <= haddr;
            write_q    <= hwrite;
            size_q     <= hsize[1:0];
            hready_out <= 1'b0;
            if (illegal) begin
              hresp <= HRESP_ERROR;
              state <= ERR1;
            end else begin
              hresp <= HRESP_OKAY;
              state <= LATCH;
            end
          end else begin
            hready_out <= 1'b1;
            hresp      <= HRESP_OKAY;
            state      <= IDLE;
          end
        end
        LATCH: begin
          paddr  <= {addr_q[AW-1:2], 2'b00};
          pwrite <= write_q;
          psel   <= 1'b1;
          pstrb  <= write_q ? strb : 4'b0000;
          if (write_q) pwdata <= hwdata;
          state  <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          cnt <= cnt + 32'd1;
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (!write_q) hrdata <= prdata;
            if (pslverr) begin
              hresp <= HRESP_ERROR;
              state <= ERR1;
            end else begin
              hready_out <= 1'b1;
              hresp      <= HRESP_OKAY;
              state      <= RESP;
            end
          end else if ((TIMEOUT != 0) && (cnt == TIMEOUT - 1)) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            hresp   <= HRESP_ERROR;
            state   <= ERR1;
          end
        end
        ERR1: begin
          hready_out <= 1'b1;
          state      <= ERR2;
        end
        default: begin
          hready_out <= 1'b1;
          hresp      <= HRESP_OKAY;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eva_ahb2apb_bridge.sv
// Scoreboard bench for eva_ahb2apb_bridge: expected APB beats and AHB
// responses are queued at drive time and popped as the DUT produces them.
module tb_eva_ahb2apb_bridge;

  localparam int unsigned TMO = 8;

  logic        hclk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int checks   = 0;
  int failures = 0;

  // APB slave model: pready after wait_n stalled ACCESS cycles.
  int unsigned wait_n  = 0;
  logic        slverr_n = 1'b0;
  logic [31:0] rdata_n  = '0;
  int unsigned acc_cnt  = 0;

  typedef struct {
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_exp_t;

  typedef struct {
    logic [1:0]  hresp;
    logic [31:0] hrdata;
  } rsp_exp_t;

  apb_exp_t apb_q[$];
  rsp_exp_t rsp_q[$];

  logic [31:0] exp_pwdata = '0;
  logic [31:0] exp_hrdata = '0;

  eva_ahb2apb_bridge #(.AW(32), .TIMEOUT(TMO)) dut (
    .hclk       (hclk),
    .rst_n      (rst_n),
    .hsel       (hsel),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .haddr      (haddr),
    .hwdata     (hwdata),
    .hready_in  (hready_in),
    .hready_out (hready_out),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pready     (pready),
    .pslverr    (pslverr),
    .prdata     (prdata)
  );

  always #5 hclk = ~hclk;

  assign pready  = psel & penable & (acc_cnt == wait_n);
  assign pslverr = pready & slverr_n;
  assign prdata  = rdata_n;

  always @(posedge hclk)
    acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [2:0] sz, input logic [31:0] a);
    case (sz)
      3'd0:    return 1'b1;
      3'd1:    return a[0] == 1'b0;
      3'd2:    return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] exp_strobe(input logic [2:0] sz, input logic [31:0] a);
    logic [3:0] byte_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] half_tbl [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1000};
    case (sz)
      3'd0:    return byte_tbl[a[1:0]];
      3'd1:    return half_tbl[a[1:0]];
      default: return 4'b1111;
    endcase
  endfunction

  // Completed APB beats are compared against the head of the APB queue.
  always @(negedge hclk) begin
    if (rst_n && psel && penable && pready) begin
      if (apb_q.size() == 0) begin
        chk("apb_unexpected", 32'(apb_q.size()), 32'd1);
      end else begin
        apb_exp_t e;
        e = apb_q.pop_front();
        chk("paddr",  paddr,  e.paddr);
        chk("pwrite", pwrite, e.pwrite);
        chk("pwdata", pwdata, e.pwdata);
        chk("pstrb",  pstrb,  e.pstrb);
      end
    end
  end

  // Call at posedge+1 in a cycle with hready_out=1; returns at posedge+1 of the
  // completion cycle so a following call issues a back-to-back address phase.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int unsigned wn, input logic err_in);
    logic        legal_x;
    logic        to;
    logic        is_err;
    int unsigned n_acc;
    int unsigned low_exp;
    int unsigned k;
    logic        done;
    apb_exp_t    a;
    rsp_exp_t    r;

    legal_x = is_legal(sz, addr);
    to      = legal_x && (wn >= TMO);
    n_acc   = to ? TMO : wn + 1;
    is_err  = !legal_x || to || err_in;
    low_exp = legal_x ? (2 + n_acc + (is_err ? 1 : 0)) : 1;

    if (legal_x && wr) exp_pwdata = wd;
    if (legal_x && !to) begin
      a.paddr  = {addr[31:2], 2'b00};
      a.pwrite = wr;
      a.pwdata = exp_pwdata;
      a.pstrb  = wr ? exp_strobe(sz, addr) : 4'b0000;
      apb_q.push_back(a);
      if (!wr) exp_hrdata = rd;
    end
    r.hresp  = is_err ? 2'b01 : 2'b00;
    r.hrdata = exp_hrdata;
    rsp_q.push_back(r);

    wait_n   = wn;
    slverr_n = err_in;
    rdata_n  = rd;

    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = sz;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;

    k = 1;
    done = 1'b0;
    while (!done && k <= 40) begin
      if (hready_out) begin
        done = 1'b1;
        r = rsp_q.pop_front();
        chk("hresp_done",   hresp,   r.hresp);
        chk("hrdata",       hrdata,  r.hrdata);
        chk("psel_done",    psel,    1'b0);
        chk("penable_done", penable, 1'b0);
        chk("wait_states",  k - 1,   low_exp);
      end else begin
        chk("psel_dphase",    psel,    legal_x && k >= 2 && k <= 2 + n_acc);
        chk("penable_dphase", penable, legal_x && k >= 3 && k <= 2 + n_acc);
        chk("hresp_dphase",   hresp,   (is_err && k == low_exp) ? 2'b01 : 2'b00);
        @(posedge hclk); #1;
        k++;
      end
    end
    if (!done) chk("dphase_bound", 32'(done), 32'd1);
  endtask

  task automatic idle_cycle();
    hsel = 1'b0; htrans = 2'b00;
    @(posedge hclk); #1;
    chk("idle_hready", hready_out, 1'b1);
    chk("idle_hresp",  hresp,      2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL sim_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
    haddr = '0; hwdata = '0; hready_in = 1'b1;
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_hready_out", hready_out, 1'b1);
    chk("rst_hresp",      hresp,      2'b00);
    chk("rst_hrdata",     hrdata,     32'h0);
    chk("rst_psel",       psel,       1'b0);
    chk("rst_penable",    penable,    1'b0);
    chk("rst_pwrite",     pwrite,     1'b0);
    chk("rst_paddr",      paddr,      32'h0);
    chk("rst_pwdata",     pwdata,     32'h0);
    chk("rst_pstrb",      pstrb,      4'h0);
    rst_n = 1'b1;

    xfer(32'h40, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 0, 1'b0);           idle_cycle();
    xfer(32'h43, 1'b1, 3'd0, 32'hAABBCCDD, 32'h0, 0, 1'b0);           idle_cycle();
    xfer(32'h40, 1'b0, 3'd2, 32'h0, 32'h12345678, 0, 1'b0);           idle_cycle();
    xfer(32'h80, 1'b1, 3'd2, 32'h01020304, 32'h0, 5, 1'b0);           idle_cycle();
    xfer(32'h44, 1'b0, 3'd2, 32'h0, 32'hCAFEF00D, 0, 1'b1);           idle_cycle();
    xfer(32'h48, 1'b0, 3'd2, 32'h0, 32'h99999999, 1000, 1'b0);        idle_cycle();
    xfer(32'h50, 1'b1, 3'd3, 32'h11111111, 32'h0, 0, 1'b0);           idle_cycle();
    xfer(32'h42, 1'b1, 3'd2, 32'h22222222, 32'h0, 0, 1'b0);           idle_cycle();
    xfer(32'h41, 1'b0, 3'd1, 32'h0, 32'h33333333, 0, 1'b0);           idle_cycle();
    xfer(32'h12, 1'b1, 3'd1, 32'h0000BEEF, 32'h0, 0, 1'b0);
    xfer(32'h14, 1'b0, 3'd2, 32'h0, 32'h87654321, 0, 1'b0);
    xfer(32'h19, 1'b1, 3'd0, 32'h00005A00, 32'h0, 2, 1'b0);           idle_cycle();

    // Abort a stalled transfer with reset while it sits in ACCESS.
    wait_n = 1000; slverr_n = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h60; hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h55AA55AA;
    repeat (2) @(posedge hclk);
    #1;
    chk("pre_rst_penable", penable, 1'b1);
    rst_n = 1'b0;
    @(posedge hclk); #1;
    chk("midrst_psel",       psel,       1'b0);
    chk("midrst_penable",    penable,    1'b0);
    chk("midrst_hready_out", hready_out, 1'b1);
    chk("midrst_hresp",      hresp,      2'b00);
    rst_n = 1'b1;
    exp_pwdata = '0;
    exp_hrdata = '0;
    xfer(32'h64, 1'b1, 3'd2, 32'h0BADF00D, 32'h0, 0, 1'b0);           idle_cycle();
    xfer(32'h64, 1'b0, 3'd2, 32'h0, 32'hFEEDFACE, 1, 1'b0);           idle_cycle();

    chk("apb_q_left", 32'(apb_q.size()), 32'd0);
    chk("rsp_q_left", 32'(rsp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
